// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline-stage register: stage occupancy states
// and ID/EX control-vector bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_t;

  localparam int CTRL_PCSRC     = 0;
  localparam int CTRL_REGWR     = 1;
  localparam int CTRL_MEM2REG   = 2;
  localparam int CTRL_MEMWR     = 3;
  localparam int CTRL_ALUCTL_LO = 4;
  localparam int CTRL_ALUCTL_HI = 6;
  localparam int CTRL_BRANCH    = 7;
  localparam int CTRL_ALUSRC    = 8;
  localparam int CTRL_FLAGWR    = 9;
  localparam int CTRL_IMMSRC    = 10;
  localparam int CTRL_COND_LO   = 11;
  localparam int CTRL_COND_HI   = 14;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (skid) entry of a pipeline stage: holds one overflow beat while the
// main entry is blocked. Captures on the falling edge like the rest of the stage.
module pipe_skid_buf #(
  parameter int W = 124
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  // push and pop are never asserted together: a full skid blocks acceptance
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (flush || pop)
        valid <= 1'b0;
      else if (push)
        valid <= 1'b1;
      if (push && !flush)
        dout <= din;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register with stall and flush, falling-edge capture.
// Build option PIPE_SKID_EN adds a skid entry so in_ready comes straight from a flop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W          = 16,
  parameter int DATA_W          = 108,
  parameter int FLUSH_DATA_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  pipe_state_t       state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              accept, emit, load_in;

  assign out_valid = (state != PS_EMPTY);
  assign emit      = out_valid & out_ready & ~stall;
  assign accept    = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic                     skid_valid, skid_push, load_skid;
  logic [CTRL_W+DATA_W-1:0] skid_q;

  assign in_ready = ~skid_valid;

  pipe_skid_buf #(.W(CTRL_W + DATA_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .pop   (load_skid),
    .flush (flush),
    .din   ({in_ctrl, in_data}),
    .valid (skid_valid),
    .dout  (skid_q)
  );
`else
  assign in_ready = ~out_valid | emit;
`endif

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state <= PS_EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
`ifdef PIPE_SKID_EN
    skid_push = 1'b0;
    load_skid = 1'b0;
`endif
    unique case (state)
      PS_EMPTY: begin
        if (accept) begin
          state_nxt = PS_FULL;
          load_in   = 1'b1;
        end
      end
      PS_FULL: begin
        if (accept && emit)
          load_in = 1'b1;
        else if (emit)
          state_nxt = PS_EMPTY;
`ifdef PIPE_SKID_EN
        else if (accept) begin
          state_nxt = PS_SKID;
          skid_push = 1'b1;
        end
`endif
      end
`ifdef PIPE_SKID_EN
      PS_SKID: begin
        if (emit) begin
          state_nxt = PS_FULL;
          load_skid = 1'b1;
        end
      end
`endif
      default: state_nxt = PS_EMPTY;
    endcase
    // Flush discards everything, including a beat handed over this cycle
    if (flush) begin
      state_nxt = PS_EMPTY;
      load_in   = 1'b0;
`ifdef PIPE_SKID_EN
      skid_push = 1'b0;
      load_skid = 1'b0;
`endif
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      if (FLUSH_DATA_ZERO != 0) main_data <= '0;
    end else if (load_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end
`ifdef PIPE_SKID_EN
    else if (load_skid) begin
      {main_ctrl, main_data} <= skid_q;
    end
`endif
  end

  // A bubble must never carry stale write-enables downstream
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = main_data;

endmodule
